fetch_unit: RTL

- Instruction-fetch stage of the MIPS core, directly upstream of the control unit.
- Owns the PC register and requests one instruction at a time from instruction memory over a valid/ready handshake.
- Holds the fetched word in an instruction register and presents it, with its PC, to decode/control; `instr[31:26]` drives the control unit's opcode.
- At retire, computes the next PC from the control outputs (Branch, Jump) and the ALU Zero flag.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 26 ++
 rtl/next_pc_calc.sv | 33 +++
 rtl/fetch_unit.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: opcodes, reset vector and fetch FSM states.
package mips_pkg;

   // Primary opcodes seen on instr[31:26]
   localparam logic [5:0] R_TYPE = 6'h00;
   localparam logic [5:0] LW     = 6'h23;
   localparam logic [5:0] SW     = 6'h2B;
   localparam logic [5:0] BEQ    = 6'h04;
   localparam logic [5:0] JUMP   = 6'h02;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

   // Clear the byte-offset bits so every PC stays word-aligned
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
interface fetch_unit_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/next_pc_calc.sv
// Next-PC selection at retire: jump beats taken branch beats fall-through.
module next_pc_calc (
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   output logic [31:0] next_pc
);

   logic [31:0] w_jump_target;
   logic [31:0] w_branch_off;
   logic [31:0] w_branch_target;
   logic        w_unused_opcode;

   assign w_jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
   assign w_branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
   assign w_branch_target = pc_plus4 + w_branch_off;

   // Opcode is decoded by the control unit, not here
   assign w_unused_opcode = ^instr[31:26];

   // Priority mux for the retire target
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = w_jump_target;
      end else if (branch && zero) begin
         next_pc = w_branch_target;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over the imem
// handshake, holds it for decode until retire, then steps the PC.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                clk,
   input  logic                rst_n,
   fetch_unit_if.master        imem,
   output logic [31:0]         instr,
   output logic                instr_valid,
   output logic [31:0]         pc,
   output logic [31:0]         pc_plus4,
   input  logic                stall,
   input  logic                branch,
   input  logic                zero,
   input  logic                jump
);

   fetch_state_e r_state;
   fetch_state_e w_state_next;

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_instr_valid;

   logic        w_req_valid;
   logic        w_rsp_take;
   logic        w_retire;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_next_pc;

   assign w_pc_plus4 = r_pc + 32'd4;

   next_pc_calc u_next_pc_calc (
      .pc_plus4 (w_pc_plus4),
      .instr    (r_instr),
      .branch   (branch),
      .zero     (zero),
      .jump     (jump),
      .next_pc  (w_next_pc)
   );

   // Next-state and handshake decode; responses outside WAIT are dropped
   always_comb begin
      w_state_next = r_state;
      w_req_valid  = 1'b0;
      w_rsp_take   = 1'b0;
      w_retire     = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_state_next = REQ;
         end
         REQ: begin
            w_req_valid = 1'b1;
            if (imem.imem_req_ready) begin
               w_state_next = WAIT;
            end
         end
         WAIT: begin
            if (imem.imem_rsp_valid) begin
               w_rsp_take   = 1'b1;
               w_state_next = HOLD;
            end
         end
         HOLD: begin
            if (r_instr_valid && !stall) begin
               w_retire     = 1'b1;
               w_state_next = REQ;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // PC advances only at retire, so it stays put across stalls and the request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= word_align(RESET_PC);
      end else if (w_retire) begin
         r_pc <= word_align(w_next_pc);
      end
   end

   // Instruction register captures the single outstanding response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= 32'h0;
      end else if (w_rsp_take) begin
         r_instr <= imem.imem_rsp_data;
      end
   end

   // Valid flag: set on capture, cleared on retire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr_valid <= 1'b0;
      end else if (w_rsp_take) begin
         r_instr_valid <= 1'b1;
      end else if (w_retire) begin
         r_instr_valid <= 1'b0;
      end
   end

   assign imem.imem_req_valid = w_req_valid;
   assign imem.imem_addr      = r_pc;

   assign instr       = r_instr;
   assign instr_valid = r_instr_valid;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;

endmodule
